// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : two-requester round-robin front end for one shared ALU
// Rev 1.0
// ============================================================================
module alu_arbiter #(
  parameter int OP_W = 5,
  parameter int W    = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic [OP_W-1:0] req0_op,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  input  logic [OP_W-1:0] req1_op,

  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [W-1:0]    rsp0_result,
  output logic            rsp0_flag,
  output logic            rsp0_illegal,

  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [W-1:0]    rsp1_result,
  output logic            rsp1_flag,
  output logic            rsp1_illegal,

  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [W-1:0]    alu_result,
  input  logic            alu_flag
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] c_LAST_LEGAL_OP = OP_W'(13);

  state_t          state_q;
  logic            last_q;
  logic            owner_q;
  logic [W-1:0]    alu_a_q;
  logic [W-1:0]    alu_b_q;
  logic [OP_W-1:0] alu_op_q;
  logic [1:0]      rsp_valid_q;
  logic [1:0]      rsp_flag_q;
  logic [1:0]      rsp_illegal_q;
  logic [W-1:0]    rsp_result_q [2];

  logic            w_idle;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_rsp_ready;
  logic [W-1:0]    rsp_result_d;
  logic            rsp_flag_d;
  logic            rsp_illegal_d;

  assign w_idle = (state_q == ST_IDLE);

  // last_q high means req1 won the previous grant, so req0 wins a tie
  assign w_gnt0 = w_idle & req0_valid & (~req1_valid | last_q);
  assign w_gnt1 = w_idle & req1_valid & (~req0_valid | ~last_q);

  assign w_rsp_ready   = owner_q ? rsp1_ready : rsp0_ready;
  assign rsp_illegal_d = (alu_op_q > c_LAST_LEGAL_OP);
  assign rsp_result_d  = rsp_illegal_d ? '0 : alu_result;
  assign rsp_flag_d    = ~rsp_illegal_d & alu_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      last_q          <= 1'b1;
      owner_q         <= 1'b0;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      alu_op_q        <= '0;
      rsp_valid_q     <= '0;
      rsp_flag_q      <= '0;
      rsp_illegal_q   <= '0;
      rsp_result_q[0] <= '0;
      rsp_result_q[1] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            owner_q  <= w_gnt1;
            last_q   <= w_gnt1;
            alu_a_q  <= w_gnt1 ? req1_a  : req0_a;
            alu_b_q  <= w_gnt1 ? req1_b  : req0_b;
            alu_op_q <= w_gnt1 ? req1_op : req0_op;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // operand registers double as the ALU drive, so they clear here
          rsp_result_q[owner_q]  <= rsp_result_d;
          rsp_flag_q[owner_q]    <= rsp_flag_d;
          rsp_illegal_q[owner_q] <= rsp_illegal_d;
          rsp_valid_q[owner_q]   <= 1'b1;
          alu_a_q                <= '0;
          alu_b_q                <= '0;
          alu_op_q               <= '0;
          state_q                <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_ready) begin
            rsp_valid_q[owner_q] <= 1'b0;
            state_q              <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready   = w_gnt0;
  assign req1_ready   = w_gnt1;
  assign rsp0_valid   = rsp_valid_q[0];
  assign rsp1_valid   = rsp_valid_q[1];
  assign rsp0_result  = rsp_result_q[0];
  assign rsp1_result  = rsp_result_q[1];
  assign rsp0_flag    = rsp_flag_q[0];
  assign rsp1_flag    = rsp_flag_q[1];
  assign rsp0_illegal = rsp_illegal_q[0];
  assign rsp1_illegal = rsp_illegal_q[1];
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;

endmodule
`default_nettype wire
